// File: rtl/hazard_stall_controller_if.sv
// Hazard-control bundle between the pipeline datapath and the stall controller.
// The master drives the ID/EX hazard information and the slave returns the stall controls.
interface hazard_stall_controller_if #(
   parameter int n  = 5,
   parameter int SW = 8
);
   logic [n-1:0]  IF_ID_rs;
   logic [n-1:0]  IF_ID_rt;
   logic          IF_ID_usesRt;
   logic [n-1:0]  ID_EX_rt;
   logic          ID_EX_memRead;
   logic          ID_mduStart;
   logic          EX_branchTaken;
   logic          pcWrite;
   logic          IF_ID_write;
   logic          IF_ID_flush;
   logic          ID_EX_bubble;
   logic          mduBusy;
   logic [SW-1:0] stallCount;

   modport master (
      output IF_ID_rs, IF_ID_rt, IF_ID_usesRt, ID_EX_rt, ID_EX_memRead,
             ID_mduStart, EX_branchTaken,
      input  pcWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble, mduBusy, stallCount
   );

   modport slave (
      input  IF_ID_rs, IF_ID_rt, IF_ID_usesRt, ID_EX_rt, ID_EX_memRead,
             ID_mduStart, EX_branchTaken,
      output pcWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble, mduBusy, stallCount
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / MDU stall and branch-flush sequencer for the 5-stage pipeline.
// Control outputs are Mealy so stalls take effect in the same cycle the hazard appears.
module hazard_stall_controller #(
   parameter int n          = 5,
   parameter int MDU_CYCLES = 4,
   parameter int CW         = 3,
   parameter int SW         = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   hazard_stall_controller_if.slave  hz
);
   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MDU_BUSY = 1'b1
   } state_t;

   localparam logic [CW-1:0] MDU_LOAD  = CW'(MDU_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [SW-1:0] STALL_MAX = {SW{1'b1}};
   localparam logic [n-1:0]  REG_ZERO  = {n{1'b0}};

   state_t        state_q, state_d;
   logic [CW-1:0] mdu_cnt_q, mdu_cnt_d;
   logic [SW-1:0] stall_count_q, stall_count_d;
   logic          load_use_s;
   logic          pc_write_s;
   logic          if_id_write_s;
   logic          if_id_flush_s;
   logic          id_ex_bubble_s;

   // $0 is hard-wired zero, so a load targeting it never creates a real dependency
   assign load_use_s = hz.ID_EX_memRead & (hz.ID_EX_rt != REG_ZERO) &
                       ((hz.ID_EX_rt == hz.IF_ID_rs) |
                        (hz.IF_ID_usesRt & (hz.ID_EX_rt == hz.IF_ID_rt)));

   // Next-state and Mealy control decode
   always_comb begin
      state_d        = state_q;
      mdu_cnt_d      = mdu_cnt_q;
      pc_write_s     = 1'b1;
      if_id_write_s  = 1'b1;
      if_id_flush_s  = 1'b0;
      id_ex_bubble_s = 1'b0;
      if (reset) begin
         state_d   = RUN;
         mdu_cnt_d = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (hz.EX_branchTaken) begin
                  if_id_flush_s  = 1'b1;
                  id_ex_bubble_s = 1'b1;
               end else if (load_use_s) begin
                  pc_write_s     = 1'b0;
                  if_id_write_s  = 1'b0;
                  id_ex_bubble_s = 1'b1;
               end else if (hz.ID_mduStart) begin
                  state_d   = MDU_BUSY;
                  mdu_cnt_d = MDU_LOAD;
               end else begin
                  state_d = RUN;
               end
            end
            MDU_BUSY: begin
               pc_write_s     = 1'b0;
               if_id_write_s  = 1'b0;
               id_ex_bubble_s = 1'b1;
               mdu_cnt_d      = mdu_cnt_q - CNT_ONE;
               if (mdu_cnt_q == CNT_ONE) begin
                  state_d = RUN;
               end else begin
                  state_d = MDU_BUSY;
               end
            end
            default: begin
               state_d   = RUN;
               mdu_cnt_d = '0;
            end
         endcase
      end
   end

   // Saturating stall counter; a branch flush keeps pcWrite high and is not counted
   always_comb begin
      stall_count_d = stall_count_q;
      if (!pc_write_s && (stall_count_q != STALL_MAX)) begin
         stall_count_d = stall_count_q + SW'(1);
      end else begin
         stall_count_d = stall_count_q;
      end
   end

   // State, MDU countdown and performance counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         mdu_cnt_q     <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         mdu_cnt_q     <= mdu_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign hz.pcWrite      = pc_write_s;
   assign hz.IF_ID_write  = if_id_write_s;
   assign hz.IF_ID_flush  = if_id_flush_s;
   assign hz.ID_EX_bubble = id_ex_bubble_s;
   assign hz.mduBusy      = (state_q == MDU_BUSY) & ~reset;
   assign hz.stallCount   = stall_count_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: directed vectors push expected outputs, a negedge monitor pops and compares.
module tb_hazard_stall_controller;
   logic clk;
   logic reset;

   hazard_stall_controller_if hz ();

   hazard_stall_controller dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   typedef struct {
      int         id;
      logic [4:0] ctl;   // {pcWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble, mduBusy}
      logic [7:0] sc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;
   bit   drive_done = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of inputs just after the rising edge and queue the expected response
   task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic [4:0] ex_rt, input logic mem_rd,
                       input logic mdu, input logic br,
                       input logic [4:0] e_ctl, input logic [7:0] e_sc);
      exp_t e;
      reset             = rst;
      hz.IF_ID_rs       = rs;
      hz.IF_ID_rt       = rt;
      hz.IF_ID_usesRt   = uses_rt;
      hz.ID_EX_rt       = ex_rt;
      hz.ID_EX_memRead  = mem_rd;
      hz.ID_mduStart    = mdu;
      hz.EX_branchTaken = br;
      e.id  = vec_id;
      e.ctl = e_ctl;
      e.sc  = e_sc;
      exp_q.push_back(e);
      vec_id++;
      @(posedge clk);
      #1;
   endtask

   localparam logic [4:0] RUNOK = 5'b11000;
   localparam logic [4:0] LUSTL = 5'b00010;
   localparam logic [4:0] BUSY  = 5'b00011;
   localparam logic [4:0] FLUSH = 5'b11110;

   // Monitor: outputs are presented every cycle, checked mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({hz.pcWrite, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_bubble, hz.mduBusy} !== e.ctl ||
                hz.stallCount !== e.sc) begin
               errors++;
               $display("FAIL vec%0d: got ctl=%b sc=%0d, expected ctl=%b sc=%0d", e.id,
                        {hz.pcWrite, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_bubble, hz.mduBusy},
                        hz.stallCount, e.ctl, e.sc);
            end
         end
      end
   end

   initial begin
      int k;
      reset             = 1'b1;
      hz.IF_ID_rs       = 5'd0;
      hz.IF_ID_rt       = 5'd0;
      hz.IF_ID_usesRt   = 1'b0;
      hz.ID_EX_rt       = 5'd0;
      hz.ID_EX_memRead  = 1'b0;
      hz.ID_mduStart    = 1'b0;
      hz.EX_branchTaken = 1'b0;
      @(posedge clk);
      #1;
      // reset ignores a live load-use hazard
      step(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, RUNOK, 8'd0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RUNOK, 8'd0);
      // load-use on rs: one stall cycle
      step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, LUSTL, 8'd0);
      step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, RUNOK, 8'd1);
      // rt match filtered by usesRt, then honoured
      step(1'b0, 5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, RUNOK, 8'd1);
      step(1'b0, 5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, LUSTL, 8'd1);
      // $0 never stalls
      step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, RUNOK, 8'd2);
      // MDU op: start cycle advances, three busy cycles ignore branch/load-use
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, RUNOK, 8'd2);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BUSY,  8'd2);
      step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, BUSY,  8'd3);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, BUSY,  8'd4);
      // back-to-back MDU accepted in first RUN cycle
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, RUNOK, 8'd5);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, BUSY,  8'd5);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, BUSY,  8'd6);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, BUSY,  8'd7);
      // branch beats load-use and MDU start, no stall counted
      step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, FLUSH, 8'd8);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RUNOK, 8'd8);
      // reset in the second busy cycle
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, RUNOK, 8'd8);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, BUSY,  8'd8);
      step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RUNOK, 8'd9);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RUNOK, 8'd0);
      // held load-use saturates the counter at 255
      for (k = 0; k < 300; k++) begin
         step(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, LUSTL, (k > 255) ? 8'd255 : 8'(k));
      end
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RUNOK, 8'd255);
      step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RUNOK, 8'd255);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RUNOK, 8'd0);
      drive_done = 1'b1;
   end

   // Drain the scoreboard with a bounded wait, then report
   initial begin
      int wait_cycles;
      wait_cycles = 0;
      while (!drive_done && wait_cycles < 5000) begin
         @(posedge clk);
         wait_cycles++;
      end
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (!drive_done || exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: pending=%0d, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline hazard sequencer that works alongside the forwarding unit in the 5-stage MIPS pipeline.
- Detects load-use hazards that forwarding cannot resolve.
- Sequences multi-cycle multiply/divide (MDU) stalls.
- Flushes wrong-path instructions on a taken branch.
- Drives the PC / IF_ID write enables and the ID_EX bubble mux, and keeps a saturating stall-cycle performance counter.

Parameters:
n, 5, register-specifier width
MDU_CYCLES, 4, cycles MDU occupies EX; legal range 2..(2^CW)
CW, 3, MDU countdown counter width
SW, 8, stall performance counter width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
IF_ID_rs  input  n  rs of instruction in ID
IF_ID_rt  input  n  rt of instruction in ID
IF_ID_usesRt  input  1  ID instruction reads rt as a source
ID_EX_rt  input  n  destination rt of instruction in EX
ID_EX_memRead  input  1  EX instruction is a load
ID_mduStart  input  1  ID instruction is a mult/div
EX_branchTaken  input  1  branch in EX resolved taken
pcWrite  output  1  PC load enable
IF_ID_write  output  1  IF_ID register load enable
IF_ID_flush  output  1  zero IF_ID contents on next edge
ID_EX_bubble  output  1  select zeroed control into ID_EX
mduBusy  output  1  state is MDU_BUSY
stallCount  output  SW  saturating count of cycles with pcWrite=0

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset:
  - On the edge where reset=1: state<=RUN, mduCnt<=0, stallCount<=0.
  - While reset=1, outputs are pcWrite=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0, mduBusy=0, and all hazard inputs are ignored.
  - Reset mid-MDU returns the block to RUN on the next edge.
- State machine: two states, RUN and MDU_BUSY. Control outputs are Mealy (state plus current inputs, same cycle, zero latency).
- loadUse = ID_EX_memRead & (ID_EX_rt!=0) & ((ID_EX_rt==IF_ID_rs) | (IF_ID_usesRt & (ID_EX_rt==IF_ID_rt))).
- RUN priority, highest first:
  1. EX_branchTaken=1: pcWrite=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1. loadUse and ID_mduStart are ignored because the ID instruction is wrong-path. Stay in RUN.
  2. loadUse=1: pcWrite=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0. Stay in RUN. ID_mduStart is ignored this cycle; it is re-evaluated when the instruction re-presents. The stall lasts exactly one cycle because the bubble clears ID_EX_memRead.
  3. ID_mduStart=1: all enables 1, bubble=0 (the MDU instruction advances to EX). Next state MDU_BUSY, mduCnt<=MDU_CYCLES-1.
  4. Otherwise: pcWrite=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0.
- MDU_BUSY:
  - Outputs: pcWrite=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0, mduBusy=1.
  - mduCnt decrements each cycle. On the cycle mduCnt==1, next state is RUN.
  - Total front-end freeze is exactly MDU_CYCLES-1 cycles, after which the ID instruction is re-evaluated in RUN.
  - EX_branchTaken, ID_mduStart and loadUse are ignored. A branch cannot be in EX behind bubbles.
- stallCount:
  - Increments by 1 on every non-reset edge where pcWrite=0.
  - Saturates at 2^SW-1; it does not wrap.
  - A branch flush is not counted as a stall.
- Back-to-back MDU ops: the second ID_mduStart is accepted in the first RUN cycle after busy; no extra dead cycle.
- Register $0 never causes a load-use stall.

Test Plan:
- Load-use on rs: ID_EX_memRead=1, ID_EX_rt=8, IF_ID_rs=8 -> one cycle with pcWrite=0, IF_ID_write=0, ID_EX_bubble=1; next cycle with memRead=0 -> all enables 1; stallCount=1.
- rt/$0 filter: ID_EX_rt=9, IF_ID_rt=9, IF_ID_usesRt=0 -> no stall. ID_EX_rt=0, IF_ID_rs=0, memRead=1 -> no stall.
- MDU with MDU_CYCLES=4: ID_mduStart pulse -> that cycle enables 1; next 3 cycles mduBusy=1, pcWrite=0, bubble=1; then RUN; stallCount=3.
- Priority: EX_branchTaken=1 together with loadUse=1 and ID_mduStart=1 -> IF_ID_flush=1, ID_EX_bubble=1, pcWrite=1, state stays RUN, stallCount unchanged.
- Reset mid-MDU: reset=1 in the 2nd busy cycle -> outputs pcWrite=1, mduBusy=0 that cycle; next cycle RUN, stallCount=0.
- Saturation with SW=8: hold loadUse for 300 cycles -> stallCount stops at 255.
